// File: rtl/conv_scan_sequencer_if.sv
// conv_scan_sequencer_if
//   Bundles the BRAM read port and the group handshake of the scan sequencer.
//   master : the sequencer (drives read requests and groups)
//   slave  : the BRAM and convolver side (returns read data, accepts groups)
//   Signals:
//     o_rd_en / o_rd_addr / i_rd_data        BRAM read port, one-cycle read latency
//     o_grp_valid / i_grp_ready              group handshake
//     o_grp0..o_grp2                         pixels at columns c, c+1, c+2
//     o_grp_row / o_grp_col                  position of the group
//     o_grp_last_row / o_grp_last            position flags
interface conv_scan_sequencer_if #(
    parameter int RAM_WIDTH    = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 10,
    parameter int IMAGE_HEIGHT = 10
);
    localparam int ROW_W = (IMAGE_HEIGHT > 32'sd1) ? $clog2(IMAGE_HEIGHT) : 32'sd1;
    localparam int COL_W = (IMAGE_WIDTH  > 32'sd1) ? $clog2(IMAGE_WIDTH)  : 32'sd1;

    logic                  o_rd_en;
    logic [ADDR_WIDTH-1:0] o_rd_addr;
    logic [RAM_WIDTH-1:0]  i_rd_data;
    logic                  o_grp_valid;
    logic                  i_grp_ready;
    logic [RAM_WIDTH-1:0]  o_grp0;
    logic [RAM_WIDTH-1:0]  o_grp1;
    logic [RAM_WIDTH-1:0]  o_grp2;
    logic [ROW_W-1:0]      o_grp_row;
    logic [COL_W-1:0]      o_grp_col;
    logic                  o_grp_last_row;
    logic                  o_grp_last;

    modport master (
        output o_rd_en, o_rd_addr,
        input  i_rd_data,
        output o_grp_valid,
        input  i_grp_ready,
        output o_grp0, o_grp1, o_grp2, o_grp_row, o_grp_col, o_grp_last_row, o_grp_last
    );

    modport slave (
        input  o_rd_en, o_rd_addr,
        output i_rd_data,
        input  o_grp_valid,
        output i_grp_ready,
        input  o_grp0, o_grp1, o_grp2, o_grp_row, o_grp_col, o_grp_last_row, o_grp_last
    );
endinterface

// File: rtl/conv_scan_sequencer.sv
// conv_scan_sequencer
//   Read-side scheduler for the single-port frame BRAM. Walks the frame one
//   column strip at a time (top to bottom inside a strip), reads three
//   horizontally adjacent pixels per group, and presents each group to the
//   convolver over a valid/ready handshake.
//   Ports:
//     clk, reset         clock, asynchronous active-high reset
//     i_start            start a scan (accepted only when idle)
//     i_abort            synchronous abort back to idle, no done pulse
//     o_busy             high whenever a scan is in progress
//     o_done             one-cycle pulse after the final group is accepted
//     bus (master)       BRAM read port and group handshake
module conv_scan_sequencer #(
    parameter int RAM_WIDTH    = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 10,
    parameter int IMAGE_HEIGHT = 10,
    parameter int KERNEL_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic                  o_done,
    conv_scan_sequencer_if.master bus
);
    localparam int ROW_W = (IMAGE_HEIGHT > 32'sd1) ? $clog2(IMAGE_HEIGHT) : 32'sd1;
    localparam int COL_W = (IMAGE_WIDTH  > 32'sd1) ? $clog2(IMAGE_WIDTH)  : 32'sd1;

    localparam logic [ROW_W-1:0]      ROW_ZERO   = {ROW_W{1'b0}};
    localparam logic [COL_W-1:0]      COL_ZERO   = {COL_W{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [RAM_WIDTH-1:0]  DATA_ZERO  = {RAM_WIDTH{1'b0}};
    localparam logic [ROW_W-1:0]      ROW_ONE    = {{(ROW_W-1){1'b0}}, 1'b1};
    localparam logic [COL_W-1:0]      COL_ONE    = {{(COL_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ROW_W-1:0]      ROW_LAST   = ROW_W'(IMAGE_HEIGHT - 32'sd1);
    localparam logic [COL_W-1:0]      COL_LAST   = COL_W'(IMAGE_WIDTH - KERNEL_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(IMAGE_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                 state_r;
    logic [1:0]             k_r;
    logic [ADDR_WIDTH-1:0]  base_r;
    logic [ADDR_WIDTH-1:0]  rd_addr_r;
    logic                   rd_en_r;
    logic [ROW_W-1:0]       row_r;
    logic [COL_W-1:0]       col_r;
    logic                   last_row_r;
    logic                   last_r;
    logic                   grp_valid_r;
    logic                   busy_r;
    logic                   done_r;
    logic [RAM_WIDTH-1:0]   slot0_r;
    logic [RAM_WIDTH-1:0]   slot1_r;
    logic [RAM_WIDTH-1:0]   slot2_r;

    logic [ROW_W-1:0]       row_inc_s;
    logic [COL_W-1:0]       col_inc_s;
    logic [ADDR_WIDTH-1:0]  base_next_row_s;
    logic [ADDR_WIDTH-1:0]  base_next_col_s;

    // Group lies on the bottom row of its strip.
    function automatic logic is_last_row(input logic [ROW_W-1:0] row);
        return (row == ROW_LAST);
    endfunction

    // Group is the bottom of the rightmost strip, i.e. the final group.
    function automatic logic is_last_grp(input logic [ROW_W-1:0] row,
                                         input logic [COL_W-1:0] col);
        return (row == ROW_LAST) && (col == COL_LAST);
    endfunction

    // Next-position arithmetic: the base address advances by additions only.
    // Moving one row down adds the row stride; starting a new strip the base
    // is simply the new column (row 0).
    assign row_inc_s       = row_r + ROW_ONE;
    assign col_inc_s       = col_r + COL_ONE;
    assign base_next_row_s = base_r + ROW_STRIDE;
    assign base_next_col_s = ADDR_WIDTH'(col_inc_s);

    // Scan FSM: issues reads, captures returned pixels, presents groups.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            k_r         <= 2'd0;
            base_r      <= ADDR_ZERO;
            rd_addr_r   <= ADDR_ZERO;
            rd_en_r     <= 1'b0;
            row_r       <= ROW_ZERO;
            col_r       <= COL_ZERO;
            last_row_r  <= 1'b0;
            last_r      <= 1'b0;
            grp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            slot0_r     <= DATA_ZERO;
            slot1_r     <= DATA_ZERO;
            slot2_r     <= DATA_ZERO;
        end else if (i_abort && (state_r != S_IDLE)) begin
            // Abort wins over everything, including a simultaneous handshake.
            state_r     <= S_IDLE;
            k_r         <= 2'd0;
            rd_en_r     <= 1'b0;
            grp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (i_start && !i_abort) begin
                        state_r    <= S_READ;
                        k_r        <= 2'd0;
                        row_r      <= ROW_ZERO;
                        col_r      <= COL_ZERO;
                        base_r     <= ADDR_ZERO;
                        rd_addr_r  <= ADDR_ZERO;
                        rd_en_r    <= 1'b1;
                        busy_r     <= 1'b1;
                        last_row_r <= is_last_row(ROW_ZERO);
                        last_r     <= is_last_grp(ROW_ZERO, COL_ZERO);
                    end else begin
                        rd_en_r     <= 1'b0;
                        grp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                S_READ: begin
                    // Read data lags the address by one cycle, so the
                    // pixel for offset k-1 arrives while offset k is issued.
                    case (k_r)
                        2'd1:    slot0_r <= bus.i_rd_data;
                        2'd2:    slot1_r <= bus.i_rd_data;
                        default: slot0_r <= slot0_r;
                    endcase
                    if (k_r == 2'd2) begin
                        state_r <= S_CAPTURE;
                        rd_en_r <= 1'b0;
                        k_r     <= 2'd0;
                    end else begin
                        k_r       <= k_r + 2'd1;
                        rd_addr_r <= rd_addr_r + ADDR_ONE;
                    end
                end
                S_CAPTURE: begin
                    slot2_r     <= bus.i_rd_data;
                    grp_valid_r <= 1'b1;
                    state_r     <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (bus.i_grp_ready) begin
                        grp_valid_r <= 1'b0;
                        if (last_r) begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                        end else if (last_row_r) begin
                            state_r    <= S_READ;
                            k_r        <= 2'd0;
                            row_r      <= ROW_ZERO;
                            col_r      <= col_inc_s;
                            base_r     <= base_next_col_s;
                            rd_addr_r  <= base_next_col_s;
                            rd_en_r    <= 1'b1;
                            last_row_r <= is_last_row(ROW_ZERO);
                            last_r     <= is_last_grp(ROW_ZERO, col_inc_s);
                        end else begin
                            state_r    <= S_READ;
                            k_r        <= 2'd0;
                            row_r      <= row_inc_s;
                            base_r     <= base_next_row_s;
                            rd_addr_r  <= base_next_row_s;
                            rd_en_r    <= 1'b1;
                            last_row_r <= is_last_row(row_inc_s);
                            last_r     <= is_last_grp(row_inc_s, col_r);
                        end
                    end else begin
                        // Stalled: hold the group, issue no reads.
                        state_r <= S_PRESENT;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r     <= S_IDLE;
                    rd_en_r     <= 1'b0;
                    grp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy             = busy_r;
    assign o_done             = done_r;
    assign bus.o_rd_en        = rd_en_r;
    assign bus.o_rd_addr      = rd_addr_r;
    assign bus.o_grp_valid    = grp_valid_r;
    assign bus.o_grp0         = slot0_r;
    assign bus.o_grp1         = slot1_r;
    assign bus.o_grp2         = slot2_r;
    assign bus.o_grp_row      = row_r;
    assign bus.o_grp_col      = col_r;
    assign bus.o_grp_last_row = last_row_r;
    assign bus.o_grp_last     = last_r;
endmodule

// File: tb/tb_conv_scan_sequencer.sv
// Testbench for conv_scan_sequencer: a 10x10 instance and a 5x4 instance,
// each with a BRAM model holding data = address.
module tb_conv_scan_sequencer;
    localparam int RW = 8;
    localparam int AW = 16;
    localparam int W  = 10;
    localparam int H  = 10;
    localparam int SW = 5;
    localparam int SH = 4;

    typedef struct packed {
        int g0; int g1; int g2; int row; int col; int lr; int last;
    } grp_t;

    logic clk = 1'b0;
    logic reset;
    logic start, abort, busy, done;
    logic sm_start, sm_abort, sm_busy, sm_done;

    int n_checks = 0;
    int n_errors = 0;

    int rd_cnt = 0, hs_cnt = 0, done_cnt = 0;
    int sm_rd_cnt = 0, sm_hs_cnt = 0, sm_done_cnt = 0;
    grp_t grp_q[$];
    grp_t sm_grp_q[$];
    int   sm_addr_q[$];

    always #5 clk = ~clk;

    conv_scan_sequencer_if #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) bus ();
    conv_scan_sequencer_if #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW), .IMAGE_WIDTH(SW), .IMAGE_HEIGHT(SH)) sm_bus ();

    conv_scan_sequencer #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .KERNEL_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .i_start(start), .i_abort(abort),
        .o_busy(busy), .o_done(done), .bus(bus)
    );

    conv_scan_sequencer #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW), .IMAGE_WIDTH(SW), .IMAGE_HEIGHT(SH), .KERNEL_WIDTH(3)) sm_dut (
        .clk(clk), .reset(reset), .i_start(sm_start), .i_abort(sm_abort),
        .o_busy(sm_busy), .o_done(sm_done), .bus(sm_bus)
    );

    // BRAM models: one-cycle read latency, contents equal to the address
    always @(posedge clk) begin
        if (bus.o_rd_en) bus.i_rd_data <= bus.o_rd_addr[7:0];
        if (sm_bus.o_rd_en) sm_bus.i_rd_data <= sm_bus.o_rd_addr[7:0];
    end

    // Activity monitor: counts reads, handshakes, done pulses; logs groups
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.o_rd_en) rd_cnt <= rd_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (bus.o_grp_valid && bus.i_grp_ready) begin
                hs_cnt <= hs_cnt + 1;
                grp_q.push_back(grp_t'{int'(bus.o_grp0), int'(bus.o_grp1), int'(bus.o_grp2),
                                       int'(bus.o_grp_row), int'(bus.o_grp_col),
                                       int'(bus.o_grp_last_row), int'(bus.o_grp_last)});
            end
            if (sm_bus.o_rd_en) begin
                sm_rd_cnt <= sm_rd_cnt + 1;
                sm_addr_q.push_back(int'(sm_bus.o_rd_addr));
            end
            if (sm_done) sm_done_cnt <= sm_done_cnt + 1;
            if (sm_bus.o_grp_valid && sm_bus.i_grp_ready) begin
                sm_hs_cnt <= sm_hs_cnt + 1;
                sm_grp_q.push_back(grp_t'{int'(sm_bus.o_grp0), int'(sm_bus.o_grp1), int'(sm_bus.o_grp2),
                                          int'(sm_bus.o_grp_row), int'(sm_bus.o_grp_col),
                                          int'(sm_bus.o_grp_last_row), int'(sm_bus.o_grp_last)});
            end
        end
    end

    // Expected i-th group of a column-strip scan of an iw x ih frame
    function automatic grp_t exp_grp(input int i, input int iw, input int ih);
        int c, r, b;
        c = i / ih;
        r = i % ih;
        b = r * iw + c;
        return grp_t'{b, b + 1, b + 2, r, c, (r == ih - 1) ? 1 : 0,
                      ((c == iw - 3) && (r == ih - 1)) ? 1 : 0};
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic test_reset();
        bit got;
        reset = 1'b1; start = 1'b0; abort = 1'b0; sm_start = 1'b0; sm_abort = 1'b0;
        bus.i_grp_ready = 1'b0; sm_bus.i_grp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, bus.o_rd_en, bus.o_grp_valid, bus.o_grp_last, bus.o_grp_last_row} !== 6'b0 ||
            bus.o_rd_addr !== 16'd0 || bus.o_grp0 !== 8'd0 || bus.o_grp1 !== 8'd0 || bus.o_grp2 !== 8'd0 ||
            bus.o_grp_row !== 4'd0 || bus.o_grp_col !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b valid=%b addr=%0d expected all 0",
                     busy, done, bus.o_rd_en, bus.o_grp_valid, bus.o_rd_addr);
        end
        @(negedge clk); reset = 1'b0;
        // Reach a stalled PRESENT, then reset mid-cycle
        pulse_start();
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk); #1;
            if (bus.o_grp_valid) got = 1;
        end
        n_checks++;
        if (!got) begin n_errors++; $display("FAIL reset_reach_present: valid=0 expected 1"); end
        reset = 1'b1; #1;
        n_checks++;
        if ({busy, bus.o_grp_valid, bus.o_rd_en} !== 3'b0 || bus.o_grp2 !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_async_present: busy=%b valid=%b rd_en=%b g2=%0d expected 0",
                     busy, bus.o_grp_valid, bus.o_rd_en, bus.o_grp2);
        end
        #2 reset = 1'b0;
        // Reset during READ drops o_rd_en without an edge
        pulse_start();
        #3 reset = 1'b1; #1;
        n_checks++;
        if ({busy, bus.o_rd_en} !== 2'b0) begin
            n_errors++;
            $display("FAIL reset_async_read: busy=%b rd_en=%b expected 0", busy, bus.o_rd_en);
        end
        @(negedge clk); reset = 1'b0;
        pulse_start();
        n_checks++;
        if (busy !== 1'b1 || bus.o_rd_en !== 1'b1 || bus.o_rd_addr !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_restart: busy=%b rd_en=%b addr=%0d expected 1 1 0", busy, bus.o_rd_en, bus.o_rd_addr);
        end
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
    endtask

    task automatic test_full_scan();
        int rd0, hs0, dn0, q0;
        bit got;
        grp_t e;
        bus.i_grp_ready = 1'b1;
        @(posedge clk); #1;
        rd0 = rd_cnt; hs0 = hs_cnt; dn0 = done_cnt; q0 = grp_q.size();
        pulse_start();
        n_checks++;
        if (bus.o_rd_en !== 1'b1 || bus.o_rd_addr !== 16'd0) begin
            n_errors++; $display("FAIL scan_first_read: rd_en=%b addr=%0d expected 1 0", bus.o_rd_en, bus.o_rd_addr);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.o_grp_valid !== 1'b0) begin
            n_errors++; $display("FAIL scan_valid_early: valid=%b after 3 edges expected 0", bus.o_grp_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.o_grp_valid !== 1'b1) begin
            n_errors++; $display("FAIL scan_valid_latency: valid=%b after 4 edges expected 1", bus.o_grp_valid);
        end
        got = 0;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge clk); #1;
            if (done) got = 1;
        end
        n_checks++;
        if (!got || busy !== 1'b1) begin
            n_errors++; $display("FAIL scan_done: seen=%0d busy=%b expected 1 1", got, busy);
        end
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_errors++; $display("FAIL scan_busy_fall: busy=%b done=%b expected 0 0", busy, done);
        end
        n_checks++;
        if (rd_cnt - rd0 != 240 || hs_cnt - hs0 != 80 || done_cnt - dn0 != 1) begin
            n_errors++;
            $display("FAIL scan_counts: reads=%0d hs=%0d done=%0d expected 240 80 1",
                     rd_cnt - rd0, hs_cnt - hs0, done_cnt - dn0);
        end
        for (int i = 0; i < 80 && q0 + i < grp_q.size(); i++) begin
            e = exp_grp(i, W, H);
            n_checks++;
            if (grp_q[q0 + i] !== e) begin
                n_errors++;
                $display("FAIL scan_grp%0d: got (%0d,%0d,%0d) r%0d c%0d lr%0d l%0d expected (%0d,%0d,%0d) r%0d c%0d lr%0d l%0d",
                         i + 1, grp_q[q0+i].g0, grp_q[q0+i].g1, grp_q[q0+i].g2, grp_q[q0+i].row, grp_q[q0+i].col,
                         grp_q[q0+i].lr, grp_q[q0+i].last, e.g0, e.g1, e.g2, e.row, e.col, e.lr, e.last);
            end
        end
    endtask

    task automatic test_backpressure();
        int rd0, hs0, dn0, q0;
        bit got;
        grp_t e;
        bus.i_grp_ready = 1'b0;
        @(posedge clk); #1;
        rd0 = rd_cnt; hs0 = hs_cnt; dn0 = done_cnt; q0 = grp_q.size();
        pulse_start();
        for (int g = 0; g < 80; g++) begin
            got = 0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk); #1;
                if (bus.o_grp_valid) got = 1;
            end
            if (!got) begin
                n_checks++; n_errors++;
                $display("FAIL bp_valid_timeout: group %0d valid=0 expected 1", g + 1);
                break;
            end
            if (g == 2) begin
                for (int s = 0; s < 7; s++) begin
                    n_checks++;
                    if (bus.o_grp_valid !== 1'b1 || bus.o_rd_en !== 1'b0 || bus.o_grp0 !== 8'd20 ||
                        bus.o_grp1 !== 8'd21 || bus.o_grp2 !== 8'd22 || bus.o_grp_row !== 4'd2 ||
                        bus.o_grp_col !== 4'd0) begin
                        n_errors++;
                        $display("FAIL bp_stall_cycle%0d: valid=%b rd_en=%b (%0d,%0d,%0d) r%0d c%0d expected 1 0 (20,21,22) r2 c0",
                                 s, bus.o_grp_valid, bus.o_rd_en, bus.o_grp0, bus.o_grp1, bus.o_grp2,
                                 bus.o_grp_row, bus.o_grp_col);
                    end
                    @(negedge clk); #1;
                end
            end
            @(posedge clk); #1 bus.i_grp_ready = 1'b1;
            @(posedge clk); #1 bus.i_grp_ready = 1'b0;
        end
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (done) got = 1;
            @(negedge clk); #1;
        end
        n_checks++;
        if (!got || rd_cnt - rd0 != 240 || hs_cnt - hs0 != 80 || done_cnt - dn0 != 1) begin
            n_errors++;
            $display("FAIL bp_counts: done=%0d reads=%0d hs=%0d pulses=%0d expected 1 240 80 1",
                     got, rd_cnt - rd0, hs_cnt - hs0, done_cnt - dn0);
        end
        for (int i = 0; i < 80 && q0 + i < grp_q.size(); i++) begin
            e = exp_grp(i, W, H);
            n_checks++;
            if (grp_q[q0 + i] !== e) begin
                n_errors++;
                $display("FAIL bp_grp%0d: got (%0d,%0d,%0d) r%0d c%0d expected (%0d,%0d,%0d) r%0d c%0d",
                         i + 1, grp_q[q0+i].g0, grp_q[q0+i].g1, grp_q[q0+i].g2, grp_q[q0+i].row,
                         grp_q[q0+i].col, e.g0, e.g1, e.g2, e.row, e.col);
            end
        end
    endtask

    task automatic test_random_ready();
        int hs0, dn0, q0;
        bit got;
        grp_t e;
        bus.i_grp_ready = 1'b0;
        @(posedge clk); #1;
        hs0 = hs_cnt; dn0 = done_cnt; q0 = grp_q.size();
        pulse_start();
        got = 0;
        for (int c = 0; c < 6000 && !got; c++) begin
            @(negedge clk); #1;
            if (done) got = 1;
            @(posedge clk); #1 bus.i_grp_ready = 1'($urandom_range(0, 1));
        end
        bus.i_grp_ready = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (!got || hs_cnt - hs0 != 80 || done_cnt - dn0 != 1) begin
            n_errors++;
            $display("FAIL rnd_counts: done=%0d hs=%0d pulses=%0d expected 1 80 1", got, hs_cnt - hs0, done_cnt - dn0);
        end
        for (int i = 0; i < 80 && q0 + i < grp_q.size(); i++) begin
            e = exp_grp(i, W, H);
            n_checks++;
            if (grp_q[q0 + i] !== e) begin
                n_errors++;
                $display("FAIL rnd_grp%0d: got (%0d,%0d,%0d) r%0d c%0d expected (%0d,%0d,%0d) r%0d c%0d",
                         i + 1, grp_q[q0+i].g0, grp_q[q0+i].g1, grp_q[q0+i].g2, grp_q[q0+i].row,
                         grp_q[q0+i].col, e.g0, e.g1, e.g2, e.row, e.col);
            end
        end
    endtask

    task automatic test_abort();
        int hs0, dn0, rd1;
        bit got;
        bus.i_grp_ready = 1'b1;
        @(posedge clk); #1;
        hs0 = hs_cnt; dn0 = done_cnt;
        pulse_start();
        got = 0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk); #1;
            if (hs_cnt - hs0 == 29 && bus.o_rd_en) got = 1;
        end
        n_checks++;
        if (!got) begin n_errors++; $display("FAIL abort_reach_g30: reached=0 expected 1"); end
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        n_checks++;
        if ({busy, bus.o_rd_en, bus.o_grp_valid, done} !== 4'b0) begin
            n_errors++;
            $display("FAIL abort_idle: busy=%b rd_en=%b valid=%b done=%b expected 0", busy, bus.o_rd_en, bus.o_grp_valid, done);
        end
        rd1 = rd_cnt;
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (done_cnt != dn0 || busy !== 1'b0 || rd_cnt != rd1) begin
            n_errors++;
            $display("FAIL abort_quiet: pulses=%0d busy=%b extra_reads=%0d expected 0 0 0", done_cnt - dn0, busy, rd_cnt - rd1);
        end
        // Restart from the top after abort
        bus.i_grp_ready = 1'b0;
        pulse_start();
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk); #1;
            if (bus.o_grp_valid) got = 1;
        end
        n_checks++;
        if (!got || bus.o_grp0 !== 8'd0 || bus.o_grp1 !== 8'd1 || bus.o_grp2 !== 8'd2 ||
            bus.o_grp_row !== 4'd0 || bus.o_grp_col !== 4'd0) begin
            n_errors++;
            $display("FAIL abort_restart: valid=%0d (%0d,%0d,%0d) r%0d c%0d expected 1 (0,1,2) r0 c0",
                     got, bus.o_grp0, bus.o_grp1, bus.o_grp2, bus.o_grp_row, bus.o_grp_col);
        end
        // Abort together with a handshake: abort wins, no more reads
        @(posedge clk); #1 bus.i_grp_ready = 1'b1; abort = 1'b1;
        @(posedge clk); #1 bus.i_grp_ready = 1'b0; abort = 1'b0;
        rd1 = rd_cnt;
        repeat (6) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || bus.o_rd_en !== 1'b0 || rd_cnt != rd1 || done_cnt != dn0) begin
            n_errors++;
            $display("FAIL abort_vs_accept: busy=%b rd_en=%b extra_reads=%0d pulses=%0d expected 0 0 0 0",
                     busy, bus.o_rd_en, rd_cnt - rd1, done_cnt - dn0);
        end
        // Abort together with start in IDLE: remain idle
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || bus.o_rd_en !== 1'b0) begin
            n_errors++; $display("FAIL abort_with_start: busy=%b rd_en=%b expected 0 0", busy, bus.o_rd_en);
        end
    endtask

    task automatic test_start_busy();
        int rd0, hs0, dn0, q0;
        bit got;
        grp_t e;
        bus.i_grp_ready = 1'b0;
        @(posedge clk); #1;
        rd0 = rd_cnt; hs0 = hs_cnt; dn0 = done_cnt; q0 = grp_q.size();
        pulse_start();
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk); #1;
            if (bus.o_grp_valid) got = 1;
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n_checks++;
        if (!got || bus.o_grp_valid !== 1'b1 || bus.o_rd_en !== 1'b0 || bus.o_grp0 !== 8'd0 || bus.o_grp2 !== 8'd2) begin
            n_errors++;
            $display("FAIL busy_start_hold: valid=%b rd_en=%b g0=%0d g2=%0d expected 1 0 0 2",
                     bus.o_grp_valid, bus.o_rd_en, bus.o_grp0, bus.o_grp2);
        end
        bus.i_grp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge clk); #1;
            if (done) got = 1;
        end
        @(negedge clk); #1;
        n_checks++;
        if (!got || rd_cnt - rd0 != 240 || hs_cnt - hs0 != 80 || done_cnt - dn0 != 1) begin
            n_errors++;
            $display("FAIL busy_start_counts: done=%0d reads=%0d hs=%0d pulses=%0d expected 1 240 80 1",
                     got, rd_cnt - rd0, hs_cnt - hs0, done_cnt - dn0);
        end
        for (int i = 0; i < 80 && q0 + i < grp_q.size(); i++) begin
            e = exp_grp(i, W, H);
            n_checks++;
            if (grp_q[q0 + i] !== e) begin
                n_errors++;
                $display("FAIL busy_start_grp%0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                         i + 1, grp_q[q0+i].g0, grp_q[q0+i].g1, grp_q[q0+i].g2, e.g0, e.g1, e.g2);
            end
        end
        bus.i_grp_ready = 1'b0;
    endtask

    task automatic test_variant();
        bit got;
        grp_t e;
        int na;
        sm_bus.i_grp_ready = 1'b1;
        @(posedge clk); #1 sm_start = 1'b1;
        @(posedge clk); #1 sm_start = 1'b0;
        got = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk); #1;
            if (sm_done) got = 1;
        end
        @(negedge clk); #1;
        n_checks++;
        if (!got || sm_hs_cnt != 12 || sm_rd_cnt != 36 || sm_done_cnt != 1 || sm_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL var_counts: done=%0d hs=%0d reads=%0d pulses=%0d busy=%b expected 1 12 36 1 0",
                     got, sm_hs_cnt, sm_rd_cnt, sm_done_cnt, sm_busy);
        end
        for (int i = 0; i < 12 && i < sm_grp_q.size(); i++) begin
            e = exp_grp(i, SW, SH);
            n_checks++;
            if (sm_grp_q[i] !== e) begin
                n_errors++;
                $display("FAIL var_grp%0d: got (%0d,%0d,%0d) r%0d c%0d lr%0d l%0d expected (%0d,%0d,%0d) r%0d c%0d lr%0d l%0d",
                         i + 1, sm_grp_q[i].g0, sm_grp_q[i].g1, sm_grp_q[i].g2, sm_grp_q[i].row, sm_grp_q[i].col,
                         sm_grp_q[i].lr, sm_grp_q[i].last, e.g0, e.g1, e.g2, e.row, e.col, e.lr, e.last);
            end
        end
        na = sm_addr_q.size();
        n_checks++;
        if (na < 3 || sm_addr_q[na-3] != 17 || sm_addr_q[na-2] != 18 || sm_addr_q[na-1] != 19) begin
            n_errors++;
            $display("FAIL var_last_addrs: count=%0d last=%0d,%0d,%0d expected 17,18,19", na,
                     (na >= 3) ? sm_addr_q[na-3] : -1, (na >= 2) ? sm_addr_q[na-2] : -1, (na >= 1) ? sm_addr_q[na-1] : -1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full_scan();
        test_backpressure();
        test_random_ready();
        test_abort();
        test_start_busy();
        test_variant();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/conv_scan_sequencer.md
# conv_scan_sequencer

Read-side scheduler for the single-port frame BRAM. Once a frame is resident, it walks the image column-strip by column-strip. Each group it emits is KERNEL_WIDTH horizontally contiguous pixels, and it steps one row per group. It issues the BRAM read addresses, captures the returned pixels and presents each complete group to the convolver over a valid/ready handshake. It owns the BRAM read port between frame load and frame readback.

## Interface
Parameters:
- RAM_WIDTH, 8, pixel width
- ADDR_WIDTH, 16, BRAM address width; must be ≥ clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
- IMAGE_WIDTH, 10, pixels per row
- IMAGE_HEIGHT, 10, rows per frame
- KERNEL_WIDTH, 3, pixels per group; fixed at 3 in this revision

Ports:
- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- i_start  in  1  begin a scan; honoured only in IDLE
- i_abort  in  1  synchronous abort; returns to IDLE and does not pulse o_done
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse after the final group is accepted
- o_rd_en  out  1  BRAM read enable
- o_rd_addr  out  ADDR_WIDTH  BRAM read address
- i_rd_data  in  RAM_WIDTH  BRAM data; valid in the cycle after the BRAM samples o_rd_en/o_rd_addr
- o_grp_valid  out  1  group available for the convolver
- i_grp_ready  in  1  convolver accepts the group
- o_grp0, o_grp1, o_grp2  out  RAM_WIDTH each  pixels at column c, c+1, c+2
- o_grp_row  out  clog2(IMAGE_HEIGHT)  row of the current group
- o_grp_col  out  clog2(IMAGE_WIDTH)  leftmost column of the current group
- o_grp_last_row  out  1  current group is in row IMAGE_HEIGHT-1
- o_grp_last  out  1  current group is the final group of the frame

## Operation
- FSM states: IDLE, READ, CAPTURE, PRESENT, DONE.
- IDLE:
  - When i_start=1 and i_abort=0, load row=0, col=0, base=0, k=0, then go to READ.
- READ (3 cycles, k=0..2):
  - Drive o_rd_en=1 and o_rd_addr=base+k.
  - Capture i_rd_data into slot k-1 whenever k>0.
  - After k=2, go to CAPTURE.
- CAPTURE (1 cycle):
  - o_rd_en=0.
  - Capture i_rd_data into slot 2.
  - Go to PRESENT.
- PRESENT:
  - o_grp_valid=1.
  - Data, row, col and flags are held stable until i_grp_ready=1.
  - On acceptance:
    - If o_grp_last: go to DONE.
    - Else if row==IMAGE_HEIGHT-1: set row=0, col=col+1, base=col+1, then go to READ.
    - Else: set row=row+1, base=base+IMAGE_WIDTH, then go to READ.
- DONE:
  - o_done=1 for exactly one cycle, then go to IDLE.
- Scan order and counts:
  - Column strips run 0..IMAGE_WIDTH-KERNEL_WIDTH; rows run 0..IMAGE_HEIGHT-1 within each strip.
  - Groups per frame = (IMAGE_WIDTH-KERNEL_WIDTH+1)*IMAGE_HEIGHT.
  - Reads per frame = 3 × groups per frame.
- Flag definitions:
  - o_grp_last = (col==IMAGE_WIDTH-KERNEL_WIDTH) && (row==IMAGE_HEIGHT-1).
  - o_grp_last_row = (row==IMAGE_HEIGHT-1).
- Arithmetic: base is a ADDR_WIDTH-bit incremental register. No multiplier. The address never exceeds IMAGE_WIDTH*IMAGE_HEIGHT-1.
- Boundary cases:
  - i_start outside IDLE is ignored.
  - i_abort in any state other than IDLE moves to IDLE on the next edge: o_rd_en, o_grp_valid and o_busy go to 0, and there is no o_done.
  - i_abort together with valid&ready: abort wins and no further reads are issued.
  - i_abort together with i_start in IDLE: stay in IDLE.
  - Asserting reset mid-scan drops o_rd_en and o_grp_valid combinationally through the flops, with no edge needed.
  - No reads are issued while PRESENT is stalled.

## Timing
- Reset values: every output is 0, state=IDLE, all counters and slots are 0.
- All outputs are registered.
- i_start is sampled at edge E0. o_rd_en is high in the cycles after E0, E1 and E2, with addresses base, base+1, base+2.
- The BRAM samples at E1, E2, E3. Slots are captured at E2, E3, E4.
- o_grp_valid is high from E4.
- With i_grp_ready held high, acceptance happens at E5. The next group's first read follows E5, so the group period is 5 cycles.
- o_done is high in the cycle after the accepting edge of the last group.
- o_busy falls one cycle after o_done.

## Test plan
- Reset:
  - Stimulus: assert reset asynchronously mid-cycle.
  - Required response: all outputs are 0 before the next edge and o_busy=0; i_start is honoured after release.
- Full 10x10 scan:
  - Stimulus: BRAM model preloaded with data=addr; i_grp_ready=1; pulse i_start.
  - Required response, group order and data:
    - Group 1: (0,1,2), row 0, col 0.
    - Group 2: (10,11,12).
    - Group 11: (1,2,3), col 1.
    - Group 80: (97,98,99), with o_grp_last=1.
  - Required response, timing and counts:
    - Exactly 240 o_rd_en cycles and 80 handshakes.
    - First o_grp_valid appears 4 edges after start.
    - o_done pulses once.
- Backpressure:
  - Stimulus: hold i_grp_ready=0 for 7 cycles on group 3.
  - Required response: (20,21,22), row 2, held stable; o_rd_en=0 throughout the stall; the scan resumes correctly.
  - Additional stimulus: drive i_grp_ready with a random pattern for the full scan.
  - Required response: the same 80-group sequence.
- Abort:
  - Stimulus: i_abort during READ of group 30.
  - Required response: IDLE next edge; o_busy=0; no o_done.
  - Follow-up: a new i_start restarts at group (0,1,2).
- Start while busy:
  - Stimulus: pulse i_start during PRESENT.
  - Required response: the scan continues unchanged, with no restart and no extra reads.
- Parameter variant IMAGE_WIDTH=5, IMAGE_HEIGHT=4:
  - Required response: 12 groups; the last group reads addresses 17,18,19 with row 3 and col 2.
